// File: rtl/quad_encoder_gen.sv
// Quadrature A/B generator: emits N Gray-coded edges, P clocks apart, and tracks position.
// Optional build macro ENC_GEN_ABORT_EN adds a cmd_abort input that stops a running command.
module quad_encoder_gen #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
`ifdef ENC_GEN_ABORT_EN
  input  logic             cmd_abort,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  output logic [1:0]       enc,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pos_count
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // RUN   | emitting edges, timer counts down to the next edge
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [1:0]       enc_nxt;
  logic [CNT_W-1:0] pos_nxt;
  logic [CNT_W-1:0] remaining, rem_nxt;
  logic [DIV_W-1:0] timer, timer_nxt;
  logic [DIV_W-1:0] period, period_nxt;
  logic             dir, dir_nxt;
  logic             done_nxt;
  logic             abort;
  logic [CNT_W-1:0] mag;
  logic [DIV_W-1:0] per;

`ifdef ENC_GEN_ABORT_EN
  assign abort = cmd_abort;
`else
  assign abort = 1'b0;
`endif

  // Negating the most negative value yields 2^(CNT_W-1) when read as unsigned.
  assign mag = cmd_steps[CNT_W-1] ? (~cmd_steps + CNT_W'(1)) : cmd_steps;
  assign per = (cmd_period == '0) ? DIV_W'(1) : cmd_period;

  assign busy      = (state == RUN);
  assign cmd_ready = ~busy;

  // dir=1 is reverse: 00->10->11->01; forward: 00->01->11->10.
  function automatic logic [1:0] gray_step(input logic [1:0] cur, input logic rev);
    logic [1:0] r;
    case (cur)
      2'b00:   r = rev ? 2'b10 : 2'b01;
      2'b01:   r = rev ? 2'b00 : 2'b11;
      2'b11:   r = rev ? 2'b01 : 2'b10;
      default: r = rev ? 2'b11 : 2'b00;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt  = state;
    enc_nxt    = enc;
    pos_nxt    = pos_count;
    rem_nxt    = remaining;
    timer_nxt  = timer;
    period_nxt = period;
    dir_nxt    = dir;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          dir_nxt = cmd_steps[CNT_W-1];
          if (mag == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt  = RUN;
            rem_nxt    = mag;
            timer_nxt  = per;
            period_nxt = per;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          rem_nxt   = '0;
          timer_nxt = '0;
        end else if (timer == DIV_W'(1)) begin
          enc_nxt = gray_step(enc, dir);
          pos_nxt = dir ? (pos_count - CNT_W'(1)) : (pos_count + CNT_W'(1));
          if (remaining == CNT_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            rem_nxt   = '0;
            timer_nxt = '0;
          end else begin
            rem_nxt   = remaining - CNT_W'(1);
            timer_nxt = period;
          end
        end else begin
          timer_nxt = timer - DIV_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      enc       <= 2'b00;
      pos_count <= '0;
      remaining <= '0;
      timer     <= '0;
      period    <= DIV_W'(1);
      dir       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      enc       <= enc_nxt;
      pos_count <= pos_nxt;
      remaining <= rem_nxt;
      timer     <= timer_nxt;
      period    <= period_nxt;
      dir       <= dir_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen; hand-computed enc/pos_count/handshake sequences.
module tb_quad_encoder_gen;
  localparam int CNT_W = 16;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps = '0;
  logic [DIV_W-1:0] cmd_period = '0;
  logic [1:0]       enc;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pos_count;
`ifdef ENC_GEN_ABORT_EN
  logic             cmd_abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  quad_encoder_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk(clk),
    .reset(reset),
`ifdef ENC_GEN_ABORT_EN
    .cmd_abort(cmd_abort),
`endif
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps),
    .cmd_period(cmd_period),
    .enc(enc),
    .busy(busy),
    .done(done),
    .pos_count(pos_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (enc !== 2'b00 || pos_count !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: enc=%b pos=%h busy=%b done=%b ready=%b, want 00 0000 0 0 1",
               enc, pos_count, busy, done, cmd_ready);
    end
  endtask

  task automatic test_forward();
    logic [1:0] exp_enc [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] prev = 2'b00;
    do_reset();
    cmd_valid = 1'b1; cmd_steps = 16'd4; cmd_period = 16'd3;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0 || enc !== 2'b00) begin
      errors++;
      $display("FAIL fwd_accept: busy=%b ready=%b enc=%b, want 1 0 00", busy, cmd_ready, enc);
    end
    for (int k = 0; k < 4; k++) begin
      for (int c = 1; c < 3; c++) begin
        tick();
        checks++;
        if (enc !== prev || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL fwd_hold k=%0d c=%0d: enc=%b busy=%b done=%b, want %b 1 0", k, c, enc, busy, done, prev);
        end
      end
      tick();
      checks++;
      if (enc !== exp_enc[k] || pos_count !== 16'(k + 1)) begin
        errors++;
        $display("FAIL fwd_edge k=%0d: enc=%b pos=%h, want %b %h", k, enc, pos_count, exp_enc[k], 16'(k + 1));
      end
      prev = exp_enc[k];
      if (k < 3) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL fwd_mid k=%0d: busy=%b done=%b, want 1 0", k, busy, done);
        end
      end else begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b1) begin
          errors++;
          $display("FAIL fwd_done: busy=%b done=%b ready=%b, want 0 1 1", busy, done, cmd_ready);
        end
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || enc !== 2'b00 || pos_count !== 16'd4) begin
      errors++;
      $display("FAIL fwd_after: done=%b enc=%b pos=%h, want 0 00 0004", done, enc, pos_count);
    end
  endtask

  task automatic test_reverse_p0();
    logic [1:0]  exp_enc [3] = '{2'b10, 2'b11, 2'b01};
    logic [15:0] exp_pos [3] = '{16'hFFFF, 16'hFFFE, 16'hFFFD};
    do_reset();
    cmd_valid = 1'b1; cmd_steps = 16'hFFFD; cmd_period = 16'd0;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (enc !== exp_enc[k] || pos_count !== exp_pos[k] || done !== (k == 2) || busy !== (k != 2)) begin
        errors++;
        $display("FAIL rev_edge k=%0d: enc=%b pos=%h done=%b busy=%b, want %b %h %b %b",
                 k, enc, pos_count, done, busy, exp_enc[k], exp_pos[k], k == 2, k != 2);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rev_after: done=%b, want 0", done);
    end
  endtask

  // Runs from the state test_reverse_p0 leaves: enc=01, pos=FFFD.
  task automatic test_zero_steps();
    cmd_valid = 1'b1; cmd_steps = 16'd0; cmd_period = 16'd5;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || enc !== 2'b01 || pos_count !== 16'hFFFD) begin
      errors++;
      $display("FAIL zero_accept: busy=%b done=%b enc=%b pos=%h, want 0 1 01 fffd", busy, done, enc, pos_count);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || enc !== 2'b01 || pos_count !== 16'hFFFD) begin
      errors++;
      $display("FAIL zero_after: busy=%b done=%b enc=%b pos=%h, want 0 0 01 fffd", busy, done, enc, pos_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cmd_valid = 1'b1; cmd_steps = 16'hFFFF; cmd_period = 16'd1;
    tick();
    cmd_steps = 16'd2;
    tick();
    checks++;
    if (enc !== 2'b10 || pos_count !== 16'hFFFF || done !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: enc=%b pos=%h done=%b ready=%b, want 10 ffff 1 1", enc, pos_count, done, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || enc !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b enc=%b, want 1 0 10", busy, done, enc);
    end
    tick();
    checks++;
    if (enc !== 2'b00 || pos_count !== 16'h0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wrap: enc=%b pos=%h busy=%b, want 00 0000 1", enc, pos_count, busy);
    end
    tick();
    checks++;
    if (enc !== 2'b01 || pos_count !== 16'h0001 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: enc=%b pos=%h done=%b busy=%b, want 01 0001 1 0", enc, pos_count, done, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    cmd_valid = 1'b1; cmd_steps = 16'd5; cmd_period = 16'd2;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (enc !== 2'b11 || pos_count !== 16'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: enc=%b pos=%h busy=%b, want 11 0002 1", enc, pos_count, busy);
    end
    reset = 1'b1;
    cmd_valid = 1'b1; cmd_steps = 16'd3;
    tick();
    checks++;
    if (enc !== 2'b00 || pos_count !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: enc=%b pos=%h busy=%b done=%b, want 00 0000 0 0", enc, pos_count, busy, done);
    end
    reset = 1'b0;
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || enc !== 2'b00) begin
      errors++;
      $display("FAIL rst_after: busy=%b done=%b enc=%b, want 0 0 00", busy, done, enc);
    end
  endtask

  task automatic test_busy_ignore();
    do_reset();
    cmd_valid = 1'b1; cmd_steps = 16'd2; cmd_period = 16'd3;
    tick();
    cmd_steps = 16'd5; cmd_period = 16'd1;
    repeat (3) tick();
    checks++;
    if (enc !== 2'b01 || pos_count !== 16'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ign_mid: enc=%b pos=%h busy=%b, want 01 0001 1", enc, pos_count, busy);
    end
    repeat (3) tick();
    cmd_valid = 1'b0;
    checks++;
    if (enc !== 2'b11 || pos_count !== 16'd2 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_end: enc=%b pos=%h done=%b busy=%b, want 11 0002 1 0", enc, pos_count, done, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || pos_count !== 16'd2 || enc !== 2'b11) begin
      errors++;
      $display("FAIL ign_after: busy=%b pos=%h enc=%b, want 0 0002 11", busy, pos_count, enc);
    end
  endtask

`ifdef ENC_GEN_ABORT_EN
  task automatic test_abort();
    do_reset();
    cmd_valid = 1'b1; cmd_steps = 16'd10; cmd_period = 16'd4;
    tick();
    cmd_valid = 1'b0;
    repeat (8) tick();
    checks++;
    if (enc !== 2'b11 || pos_count !== 16'd2) begin
      errors++;
      $display("FAIL abort_pre: enc=%b pos=%h, want 11 0002", enc, pos_count);
    end
    repeat (3) tick();
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    checks++;
    if (enc !== 2'b11 || pos_count !== 16'd2 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL abort_edge: enc=%b pos=%h busy=%b done=%b, want 11 0002 0 1", enc, pos_count, busy, done);
    end
    repeat (6) tick();
    checks++;
    if (enc !== 2'b11 || pos_count !== 16'd2 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: enc=%b pos=%h done=%b busy=%b, want 11 0002 0 0", enc, pos_count, done, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_reverse_p0();
    test_zero_steps();
    test_back_to_back();
    test_reset_mid_run();
    test_busy_ignore();
`ifdef ENC_GEN_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
